// File: rtl/axi4lite_timer_pkg.sv
// Shared types and constants for the AXI4-Lite timer register controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package axi4lite_timer_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_PEND,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PEND,
        R_WAIT,
        R_RESP
    } rd_state_t;

    // A register address is usable when it is word aligned and inside the map.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned num_regs);
        return (addr[1:0] == 2'b00) && (addr < num_regs * 4);
    endfunction

endpackage

// File: rtl/axi4lite_rr_arb2.sv
// Two-requester round-robin arbiter for the single register-access slot.
// Latency: combinational grant in the request cycle; last-winner flop updates on the edge.
// Backpressure: a losing requester simply keeps requesting and wins the following cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; req_wr_i/req_rd_i requests;
//        gnt_wr_o/gnt_rd_o one-hot (or zero) grants.
module axi4lite_rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    // 1 = write won the most recent contested cycle. Resetting to "read" makes
    // the first conflict go to the write channel. Only contested cycles move
    // this flop, so back-to-back conflicts alternate their winner.
    logic last_wr_q;

    assign gnt_wr_o = req_wr_i && (!req_rd_i || !last_wr_q);
    assign gnt_rd_o = req_rd_i && (!req_wr_i ||  last_wr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_wr_q <= 1'b0;
        end else if (req_wr_i && req_rd_i) begin
            last_wr_q <= gnt_wr_o;
        end
    end

endmodule

// File: rtl/axi4lite_timer_ctrl.sv
// AXI4-Lite slave front end for the timer register block: latches AW/W, validates,
// arbitrates one register-access slot between writes and reads, returns B/R responses.
// Latency: AW+W -> wr_en next cycle -> BVALID the cycle after; AR -> rd_en next cycle,
//          RVALID one cycle after rd_valid (or after RD_TIMEOUT wait cycles).
// Backpressure: one outstanding transaction per channel; AW/W/AR are not accepted
//          again until the B/R handshake completes, responses held until BREADY/RREADY.
// Ports: AXI4-Lite slave channels AW/W/B/AR/R on ACLK/ARESETn; wr_en/wr_addr/wr_data
//        and rd_en/rd_addr single-cycle strobes to the register block; rd_data/rd_valid return.
module axi4lite_timer_ctrl
    import axi4lite_timer_pkg::*;
#(
    parameter int          ADDR_W     = 4,
    parameter int          DATA_W     = 32,
    parameter int unsigned NUM_REGS   = 4,
    parameter int          RD_TIMEOUT = 8
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_valid
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    // Holds the ready outputs low through reset and for the release edge itself.
    logic ready_en_q;

    wr_state_t             wr_state_q, wr_state_d;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [DATA_W/8-1:0]   w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;

    rd_state_t             rd_state_q, rd_state_d;
    logic [ADDR_W-1:0]     ar_addr_q, ar_addr_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic aw_hs, w_hs, ar_hs;
    logic wr_ok, rd_ok;
    logic req_wr, req_rd, gnt_wr, gnt_rd;

    assign AWREADY = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_D);
    assign WREADY  = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_A);
    assign ARREADY = ready_en_q && (rd_state_q == R_IDLE);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    assign wr_ok = addr_ok(32'(aw_addr_q), NUM_REGS) && (w_strb_q == '1);
    assign rd_ok = addr_ok(32'(ar_addr_q), NUM_REGS);

    // Invalid accesses never touch the register block, so they never request.
    assign req_wr = (wr_state_q == W_PEND) && wr_ok;
    assign req_rd = (rd_state_q == R_PEND) && rd_ok;

    axi4lite_rr_arb2 u_arb (
        .clk_i    (ACLK),
        .rst_ni   (ARESETn),
        .req_wr_i (req_wr),
        .req_rd_i (req_rd),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    assign wr_en   = gnt_wr;
    assign wr_addr = aw_addr_q;
    assign wr_data = w_data_q;
    assign rd_en   = gnt_rd;
    assign rd_addr = ar_addr_q;

    assign BVALID = (wr_state_q == W_RESP);
    assign BRESP  = bresp_q;
    assign RVALID = (rd_state_q == R_RESP);
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;

        if (aw_hs) begin
            aw_addr_d = AWADDR;
        end
        if (w_hs) begin
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_PEND;
                else if (aw_hs)    wr_state_d = W_HAVE_A;
                else if (w_hs)     wr_state_d = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)  wr_state_d = W_PEND;
            W_HAVE_D: if (aw_hs) wr_state_d = W_PEND;
            W_PEND: begin
                if (!wr_ok) begin
                    bresp_d    = RESP_SLVERR;
                    wr_state_d = W_RESP;
                end else if (gnt_wr) begin
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP:  if (BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_addr_d  = ar_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_addr_d  = ARADDR;
                    rd_state_d = R_PEND;
                end
            end
            R_PEND: begin
                if (!rd_ok) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end else if (gnt_rd) begin
                    tmo_cnt_d  = '0;
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                // A late rd_valid in the final wait cycle still wins over the timeout.
                if (rd_valid) begin
                    rdata_d    = rd_data;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = R_RESP;
                end else if (tmo_cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    rdata_d    = DATA_W'(RD_ERR_DATA);
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            R_RESP:  if (RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ready_en_q <= 1'b0;
            wr_state_q <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= R_IDLE;
            ar_addr_q  <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            tmo_cnt_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            ar_addr_q  <= ar_addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_timer_ctrl.sv
// Self-checking bench for axi4lite_timer_ctrl: directed scenarios plus randomized
// traffic, each transaction's strobe and response timing predicted from the
// handshake cycle, address/strobe validity, conflict winner and register-block latency.
module tb_axi4lite_timer_ctrl;

    localparam int NUM_REGS   = 4;
    localparam int RD_TIMEOUT = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID, AWREADY;
    logic [3:0]  AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [3:0]  ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    axi4lite_timer_ctrl #(
        .ADDR_W(4), .DATA_W(32), .NUM_REGS(NUM_REGS), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Register-block contents as the bench believes them to be.
    logic [31:0] mem [NUM_REGS];

    // 1 when the write channel won the most recent contested cycle.
    bit model_last_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit addr_in_map(input logic [3:0] a);
        return (int'(a) % 4 == 0) && (int'(a) / 4 < NUM_REGS);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(AWREADY), 0);
        check({tag, "_wready"},  32'(WREADY),  0);
        check({tag, "_arready"}, 32'(ARREADY), 0);
        check({tag, "_bvalid"},  32'(BVALID),  0);
        check({tag, "_rvalid"},  32'(RVALID),  0);
        check({tag, "_wr_en"},   32'(wr_en),   0);
        check({tag, "_rd_en"},   32'(rd_en),   0);
        check({tag, "_bresp"},   32'(BRESP),   0);
        check({tag, "_rresp"},   32'(RRESP),   0);
        check({tag, "_rdata"},   RDATA,        0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, wr_data,      0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    endtask

    // extra = cycles the write loses to a contending read (0 or 1).
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly, input int extra);
        bit ok;
        bit aw_done = 0, w_done = 0, fin = 0;
        int h = -1, exp_wr = 0, exp_b = 0, post = -1;
        bit strobe;
        ok = addr_in_map(a) && (s == 4'hF);
        for (int k = 0; k < 120 && !fin; k++) begin
            @(negedge ACLK);
            AWVALID = !aw_done && (k >= aw_dly);
            AWADDR  = a;
            WVALID  = !w_done && (k >= w_dly);
            WDATA   = d;
            WSTRB   = s;
            BREADY  = (h >= 0) && (post < 0) && (k == exp_b + b_dly);
            #1;
            if (post >= 0) begin
                check("wr_bvalid_drop", 32'(BVALID), 0);
                check("wr_awready_back", 32'(AWREADY), 1);
                check("wr_wready_back", 32'(WREADY), 1);
                fin = 1;
            end else begin
                strobe = ok && (h >= 0) && (k == exp_wr);
                check("wr_en", 32'(wr_en), 32'(strobe));
                if (strobe) begin
                    check("wr_addr", 32'(wr_addr), 32'(a));
                    check("wr_data", wr_data, d);
                    mem[int'(a) / 4] = d;
                end
                check("bvalid", 32'(BVALID), 32'((h >= 0) && (k >= exp_b)));
                if (h >= 0 && k >= exp_b) check("bresp", 32'(BRESP), ok ? 32'd0 : 32'd2);
                check("awready", 32'(AWREADY), 32'((h < 0) && !aw_done));
                check("wready",  32'(WREADY),  32'((h < 0) && !w_done));
                if (AWVALID && AWREADY) aw_done = 1;
                if (WVALID && WREADY)   w_done  = 1;
                if (h < 0 && aw_done && w_done) begin
                    h      = k;
                    exp_wr = k + 1 + extra;
                    exp_b  = ok ? exp_wr + 1 : k + 2;
                end
                if (BREADY) post = k;
            end
        end
        AWVALID = 0; WVALID = 0; BREADY = 0;
        check("wr_complete", 32'(fin), 1);
    endtask

    // lat: cycles from rd_en to rd_valid; -1 = never; 0 lands in the rd_en cycle.
    task automatic do_read(input logic [3:0] a, input int ar_dly, input int lat,
                           input int extra, input int r_dly);
        bit ok;
        bit ar_done = 0, fin = 0;
        int h = -1, exp_rd = 0, exp_r = 0, post = -1;
        logic [31:0] exp_dat = 0;
        logic [1:0]  exp_resp = 0;
        bit strobe;
        ok = addr_in_map(a);
        for (int k = 0; k < 120 && !fin; k++) begin
            @(negedge ACLK);
            ARVALID  = !ar_done && (k >= ar_dly);
            ARADDR   = a;
            rd_valid = ok && (h >= 0) && (lat >= 0) && (k == exp_rd + lat);
            rd_data  = rd_valid ? mem[int'(a) / 4] : $urandom;
            RREADY   = (h >= 0) && (post < 0) && (k == exp_r + r_dly);
            #1;
            if (post >= 0) begin
                check("rd_rvalid_drop", 32'(RVALID), 0);
                check("rd_arready_back", 32'(ARREADY), 1);
                fin = 1;
            end else begin
                strobe = ok && (h >= 0) && (k == exp_rd);
                check("rd_en", 32'(rd_en), 32'(strobe));
                if (strobe) check("rd_addr", 32'(rd_addr), 32'(a));
                check("arready", 32'(ARREADY), 32'(h < 0));
                check("rvalid", 32'(RVALID), 32'((h >= 0) && (k >= exp_r)));
                if (h >= 0 && k >= exp_r) begin
                    check("rdata", RDATA, exp_dat);
                    check("rresp", 32'(RRESP), 32'(exp_resp));
                end
                if (ARVALID && ARREADY) begin
                    ar_done = 1;
                    h       = k;
                    exp_rd  = k + 1 + extra;
                    if (!ok) begin
                        exp_r = k + 2; exp_dat = 0; exp_resp = 2'b10;
                    end else if (lat >= 1 && lat <= RD_TIMEOUT) begin
                        exp_r = exp_rd + lat + 1; exp_dat = mem[int'(a) / 4]; exp_resp = 2'b00;
                    end else begin
                        exp_r = exp_rd + RD_TIMEOUT + 1; exp_dat = 32'hDEAD_BEEF; exp_resp = 2'b10;
                    end
                end
                if (RREADY) post = k;
            end
        end
        ARVALID = 0; RREADY = 0; rd_valid = 0;
        check("rd_complete", 32'(fin), 1);
    endtask

    // Write and read handshake in the same cycle; the model picks the winner.
    task automatic do_conflict(input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ra, input int lat, input int b_dly, input int r_dly);
        int xw;
        xw = model_last_wr ? 1 : 0;
        fork
            do_write(wa, wd, 4'hF, 0, 0, b_dly, xw);
            do_read(ra, 0, lat, 1 - xw, r_dly);
        join
        model_last_wr = (xw == 0);
    endtask

    always @(negedge ACLK) begin
        #1;
        if (wr_en || rd_en) check("wr_rd_exclusive", 32'(wr_en && rd_en), 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ARESETn = 0;
        AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; RREADY = 0; rd_data = 0; rd_valid = 0;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;

        repeat (3) @(negedge ACLK);
        #1;
        check_reset_outputs("rst");
        ARESETn = 1;
        @(negedge ACLK);
        #1;
        check("rel_awready", 32'(AWREADY), 1);
        check("rel_wready",  32'(WREADY),  1);
        check("rel_arready", 32'(ARREADY), 1);

        // Basic write, W-before-AW with B stall, reads, errors, timeout.
        do_write(4'h4, 32'h64, 4'hF, 0, 0, 0, 0);
        do_write(4'hC, 32'hCAFE_0001, 4'hF, 3, 0, 5, 0);
        mem[2] = 32'h1234;
        do_read(4'h8, 0, 2, 0, 0);
        do_read(4'h6, 0, 2, 0, 1);
        do_write(4'h0, 32'h5555_AAAA, 4'h3, 0, 0, 0, 0);
        do_read(4'h0, 0, -1, 0, 0);

        // Two conflicts in a row: winner alternates.
        do_conflict(4'h4, 32'hA1A1_0000, 4'h8, 2, 0, 0);
        do_conflict(4'h0, 32'hB2B2_0000, 4'hC, 1, 1, 2);

        // Reset while write is in W_PEND and read is in R_WAIT.
        @(negedge ACLK); ARVALID = 1; ARADDR = 4'h0; rd_valid = 0;
        @(negedge ACLK); ARVALID = 0;
        #1 check("mid_rd_en", 32'(rd_en), 1);
        @(negedge ACLK); AWVALID = 1; AWADDR = 4'h8; WVALID = 1; WDATA = 32'h7777_7777; WSTRB = 4'hF;
        @(negedge ACLK); AWVALID = 0; WVALID = 0;
        #1 check("mid_wr_en", 32'(wr_en), 1);
        ARESETn = 0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        model_last_wr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ACLK);
            #1;
            check("post_rst_wr_en",  32'(wr_en),  0);
            check("post_rst_rd_en",  32'(rd_en),  0);
            check("post_rst_bvalid", 32'(BVALID), 0);
            check("post_rst_rvalid", 32'(RVALID), 0);
        end
        do_write(4'h8, 32'h0BAD_F00D, 4'hF, 0, 1, 0, 0);
        do_read(4'h8, 1, 3, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(2, 0));
            if (kind == 0) begin
                logic [3:0] a, s;
                a = 4'($urandom_range(15, 0));
                s = ($urandom_range(3, 0) != 0) ? 4'hF : 4'($urandom);
                do_write(a, $urandom, s, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                         int'($urandom_range(3, 0)), 0);
            end else if (kind == 1) begin
                logic [3:0] a;
                a = 4'($urandom_range(15, 0));
                do_read(a, int'($urandom_range(3, 0)), int'($urandom_range(11, 0)) - 1, 0,
                        int'($urandom_range(3, 0)));
            end else begin
                logic [3:0] wa, ra;
                wa = 4'($urandom_range(1, 0) * 4);
                ra = 4'(8 + $urandom_range(1, 0) * 4);
                do_conflict(wa, $urandom, ra, int'($urandom_range(9, 1)),
                            int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
